// File: rtl/param_cpu_pkg.sv
// Shared types and helpers for param_cpu.
//   op_e      : 4-bit opcode encoding (9-14 are undefined)
//   state_e   : control FSM states
//   FLAG_*    : bit positions inside the {V,C,N,Z} flags vector
//   alu_res_t : ALU result {data, c, v}
//   alu()     : width-generic ALU. It works on ALU_MAX_W-bit containers,
//               and the caller passes the live width w (<= ALU_MAX_W).
package param_cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDI  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_LD   = 4'd7,
    OP_ST   = 4'd8,
    OP_HALT = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Package types cannot follow a module parameter, so the ALU operates on
  // a fixed maximum container width and masks down to the live width.
  localparam int ALU_MAX_W = 64;

  typedef struct packed {
    logic [ALU_MAX_W-1:0] data;
    logic                 c;
    logic                 v;
  } alu_res_t;

  function automatic alu_res_t alu(input op_e op,
                                   input logic [ALU_MAX_W-1:0] a,
                                   input logic [ALU_MAX_W-1:0] b,
                                   input int unsigned w);
    logic [ALU_MAX_W:0] one, mask, ax, bx, full;
    logic sa, sb, sr, carry;
    alu_res_t r;
    one  = {{ALU_MAX_W{1'b0}}, 1'b1};
    mask = (one << w) - one;
    ax   = {1'b0, a} & mask;
    bx   = {1'b0, b} & mask;
    case (op)
      OP_ADD:  full = ax + bx;
      OP_SUB:  full = ax - bx;
      OP_AND:  full = ax & bx;
      OP_OR:   full = ax | bx;
      OP_XOR:  full = ax ^ bx;
      default: full = '0;
    endcase
    // Bit w of the extended result is the carry for ADD. For SUB it is the
    // borrow, because the subtraction wraps and sets all upper bits.
    carry = |((full >> w) & one);
    sa    = |((ax >> (w - 1)) & one);
    sb    = |((bx >> (w - 1)) & one);
    sr    = |((full >> (w - 1)) & one);
    r      = '0;
    r.data = full[ALU_MAX_W-1:0] & mask[ALU_MAX_W-1:0];
    case (op)
      OP_ADD: begin
        r.c = carry;
        r.v = (sa == sb) && (sr != sa);
      end
      OP_SUB: begin
        r.c = carry;
        r.v = (sa != sb) && (sr != sa);
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/param_cpu_iq.sv
// Instruction queue: a synchronous FIFO with show-ahead output.
//   push/din   : write when push && !full
//   pop/dout   : dout always shows the oldest entry; pop advances it when !empty
//   full/empty : occupancy status
//   count      : number of stored entries (0..DEPTH)
// The reset clears the pointers and the count. The storage array keeps its
// contents, which become unreachable.
module param_cpu_iq #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // A push is refused when full, even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/param_cpu.sv
// param_cpu: a parametrised single-issue CPU with an instruction queue.
//   instr_valid/instr/instr_ready : instruction stream into the queue
//                                   word layout {op[3:0], rd, rs, imm}
//   mem_req/we/addr/wdata/rdata/ready : single-outstanding memory port.
//                                   The mem_* outputs are held while waiting.
//   done    : HALT executed (sticky until reset)
//   flags   : {V,C,N,Z}
//   illegal : sticky, set when an undefined opcode (9-14) is executed
//   iq_count: queue occupancy
//   dbg_ridx/dbg_rdata : combinational register read-back
module param_cpu
  import param_cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NREGS    = 4,
  parameter int ADDR_W   = 8,
  parameter int IMM_W    = 8,
  parameter int IQ_DEPTH = 4,
  localparam int RIDX_W  = $clog2(NREGS),
  localparam int IW      = 4 + 2 * RIDX_W + IMM_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        instr_valid,
  input  logic [IW-1:0]               instr,
  output logic                        instr_ready,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready,
  output logic                        done,
  output logic [3:0]                  flags,
  output logic                        illegal,
  output logic [$clog2(IQ_DEPTH):0]   iq_count,
  input  logic [RIDX_W-1:0]           dbg_ridx,
  output logic [DATA_W-1:0]           dbg_rdata
);

  logic                iq_full, iq_empty, push, pop;
  logic [IW-1:0]       iq_dout, ir;
  state_e              state_q, state_d;
  op_e                 op;
  logic [RIDX_W-1:0]   rd, rs;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [DATA_W-1:0]   rd_val, rs_val, ldi_val, alu_data;
  logic [ADDR_W-1:0]   ea;
  alu_res_t            alu_r;
  logic                alu_unused;

  assign instr_ready = !iq_full && !done;
  assign push        = instr_valid && instr_ready;

  param_cpu_iq #(.WIDTH(IW), .DEPTH(IQ_DEPTH)) u_iq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (instr),
    .pop   (pop),
    .dout  (iq_dout),
    .full  (iq_full),
    .empty (iq_empty),
    .count (iq_count)
  );

  assign op        = op_e'(ir[IW-1 -: 4]);
  assign rd        = ir[IW-5 -: RIDX_W];
  assign rs        = ir[IMM_W +: RIDX_W];
  assign imm       = ir[IMM_W-1:0];
  assign rd_val    = regs[rd];
  assign rs_val    = regs[rs];
  assign ldi_val   = DATA_W'(imm);
  assign ea        = ADDR_W'(rs_val) + ADDR_W'(imm);
  assign dbg_rdata = regs[dbg_ridx];

  assign alu_r      = alu(op, ALU_MAX_W'(rd_val), ALU_MAX_W'(rs_val), DATA_W);
  assign alu_data   = alu_r.data[DATA_W-1:0];
  assign alu_unused = ^alu_r.data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      FETCH: begin
        if (!iq_empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op)
          OP_LD, OP_ST: state_d = MEM_WAIT;
          OP_HALT:      state_d = HALTED;
          default:      state_d = FETCH;
        endcase
      end
      MEM_WAIT: if (mem_ready && mem_req) state_d = FETCH;
      HALTED:   state_d = HALTED;
      default:  state_d = FETCH;
    endcase
  end

  // Operands are read from regs before the edge, so rd==rs is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flags     <= '0;
      ir        <= '0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (pop) ir <= iq_dout;
      case (state_q)
        EXEC: begin
          case (op)
            OP_NOP: ;
            OP_LDI: begin
              regs[rd]      <= ldi_val;
              flags[FLAG_Z] <= (ldi_val == '0);
              flags[FLAG_N] <= ldi_val[DATA_W-1];
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              regs[rd]      <= alu_data;
              flags[FLAG_Z] <= (alu_data == '0);
              flags[FLAG_N] <= alu_data[DATA_W-1];
              flags[FLAG_C] <= alu_r.c;
              flags[FLAG_V] <= alu_r.v;
            end
            OP_LD, OP_ST: begin
              mem_req   <= 1'b1;
              mem_we    <= (op == OP_ST);
              mem_addr  <= ea;
              mem_wdata <= (op == OP_ST) ? rd_val : '0;
            end
            OP_HALT: done <= 1'b1;
            default: illegal <= 1'b1;
          endcase
        end
        MEM_WAIT: begin
          if (mem_ready && mem_req) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              regs[rd]      <= mem_rdata;
              flags[FLAG_Z] <= (mem_rdata == '0);
              flags[FLAG_N] <= mem_rdata[DATA_W-1];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
